// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive bit-recovery path.
package usb_rx_pkg;
  localparam int CLKS_PER_BIT_DEF = 8;
  localparam int SAMPLE_POINT_DEF = 3;
  localparam int MAX_ONES_DEF     = 6;

  typedef enum logic [1:0] {LINE_J, LINE_K, LINE_SE0, LINE_SE1} line_state_t;

  function automatic line_state_t classify(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return LINE_J;
      2'b01:   return LINE_K;
      2'b00:   return LINE_SE0;
      default: return LINE_SE1;
    endcase
  endfunction
endpackage

// File: rtl/rx_bit_recovery_if.sv
// Line-side inputs and decoded-bit outputs of the bit-recovery block.
interface rx_bit_recovery_if;
  logic enable;
  logic d_plus_sync;
  logic d_minus_sync;
  logic bit_valid;
  logic bit_out;
  logic eop;
  logic stuff_err;
  logic line_err;

  modport master (
    output enable, d_plus_sync, d_minus_sync,
    input  bit_valid, bit_out, eop, stuff_err, line_err
  );

  modport slave (
    input  enable, d_plus_sync, d_minus_sync,
    output bit_valid, bit_out, eop, stuff_err, line_err
  );
endinterface

// File: rtl/bit_phase_timer.sv
// Oversampled bit-phase counter; resyncs on every D+ edge and strobes o_samp mid-bit.
module bit_phase_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_enable,
  input  logic i_dp,
  output logic o_samp
);
  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [PW-1:0] r_phase;
  logic          r_prev_dp;
  logic          w_edge;

  assign w_edge = (i_dp != r_prev_dp);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_phase   <= '0;
      r_prev_dp <= 1'b1;
    end else begin
      r_prev_dp <= i_dp;
      if (!i_enable)
        r_phase <= '0;
      else if (w_edge)
        r_phase <= PW'(1);  // the edge cycle itself is phase 0
      else if (r_phase == PW'(CLKS_PER_BIT - 1))
        r_phase <= '0;
      else
        r_phase <= r_phase + PW'(1);
    end
  end

  // An edge landing on the sample point resyncs rather than samples.
  assign o_samp = i_enable && !w_edge && (r_phase == PW'(SAMPLE_POINT));
endmodule

// File: rtl/rx_bit_recovery.sv
// USB receive bit recovery: NRZI decode, bit unstuffing, EOP/SE1/stuff-error detection.
module rx_bit_recovery
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SAMPLE_POINT = SAMPLE_POINT_DEF,
  parameter int MAX_ONES     = MAX_ONES_DEF
) (
  input logic             clk,
  input logic             n_rst,
  rx_bit_recovery_if.slave bus
);
  localparam int OW = $clog2(MAX_ONES + 1);

  logic          w_samp;
  line_state_t   w_line;
  logic          w_dec;

  logic          r_prev_line;
  logic [OW-1:0] r_ones_cnt;
  logic [1:0]    r_se0_cnt;
  logic          r_bit_valid;
  logic          r_bit_out;
  logic          r_eop;
  logic          r_stuff_err;
  logic          r_line_err;

  bit_phase_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_POINT(SAMPLE_POINT)
  ) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_enable(bus.enable),
    .i_dp    (bus.d_plus_sync),
    .o_samp  (w_samp)
  );

  assign w_line = classify(bus.d_plus_sync, bus.d_minus_sync);
  assign w_dec  = (bus.d_plus_sync == r_prev_line);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prev_line <= 1'b1;
      r_ones_cnt  <= '0;
      r_se0_cnt   <= '0;
      r_bit_valid <= 1'b0;
      r_bit_out   <= 1'b0;
      r_eop       <= 1'b0;
      r_stuff_err <= 1'b0;
      r_line_err  <= 1'b0;
    end else begin
      r_bit_valid <= 1'b0;
      r_eop       <= 1'b0;
      r_stuff_err <= 1'b0;
      r_line_err  <= 1'b0;
      if (!bus.enable) begin
        r_ones_cnt  <= '0;
        r_se0_cnt   <= '0;
        r_prev_line <= 1'b1;
      end else if (w_samp) begin
        case (w_line)
          LINE_SE0: begin
            if (r_se0_cnt != 2'd2)
              r_se0_cnt <= r_se0_cnt + 2'd1;
            // Fires only on the 1->2 step, so long SE0 gives a single pulse.
            if (r_se0_cnt == 2'd1) begin
              r_eop       <= 1'b1;
              r_ones_cnt  <= '0;
              r_prev_line <= 1'b1;
            end
          end
          LINE_SE1: begin
            r_line_err <= 1'b1;
            r_se0_cnt  <= '0;
          end
          default: begin
            r_se0_cnt   <= '0;
            r_prev_line <= bus.d_plus_sync;
            if (r_ones_cnt == OW'(MAX_ONES)) begin
              r_ones_cnt  <= '0;
              r_stuff_err <= w_dec;
            end else begin
              r_bit_valid <= 1'b1;
              r_bit_out   <= w_dec;
              r_ones_cnt  <= w_dec ? r_ones_cnt + OW'(1) : '0;
            end
          end
        endcase
      end
    end
  end

  assign bus.bit_valid = r_bit_valid;
  assign bus.bit_out   = r_bit_out;
  assign bus.eop       = r_eop;
  assign bus.stuff_err = r_stuff_err;
  assign bus.line_err  = r_line_err;
endmodule

// File: tb/tb_rx_bit_recovery.sv
// Directed bench for rx_bit_recovery: sync, stuffing, EOP, jitter, abort and line errors.
module tb_rx_bit_recovery;
  import usb_rx_pkg::*;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  rx_bit_recovery_if bus ();

  rx_bit_recovery #(.CLKS_PER_BIT(8), .SAMPLE_POINT(3), .MAX_ONES(6)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: cumulative record of every output pulse, sampled mid-cycle.
  logic got_q[$];
  int   bv_cyc_q[$];
  int   eop_cyc_q[$];
  int   n_eop = 0, n_serr = 0, n_lerr = 0;
  always @(negedge clk) begin
    if (bus.bit_valid) begin
      got_q.push_back(bus.bit_out);
      bv_cyc_q.push_back(cyc);
    end
    if (bus.eop) begin
      n_eop++;
      eop_cyc_q.push_back(cyc);
    end
    if (bus.stuff_err) n_serr++;
    if (bus.line_err)  n_lerr++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int   b_bits, b_eop, b_serr, b_lerr;
  int   t_sync;
  logic exp_q[$];

  task automatic mark();
    b_bits = got_q.size();
    b_eop  = n_eop;
    b_serr = n_serr;
    b_lerr = n_lerr;
    exp_q.delete();
  endtask

  task automatic ex(input logic b, input int n);
    repeat (n) exp_q.push_back(b);
  endtask

  task automatic verify(input string tag, input int e_eop, input int e_serr, input int e_lerr);
    chk({tag, ".nbits"}, got_q.size() - b_bits, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (b_bits + i < got_q.size())
        chk($sformatf("%s.bit%0d", tag, i), int'(got_q[b_bits + i]), int'(exp_q[i]));
    chk({tag, ".eop"},  n_eop - b_eop,   e_eop);
    chk({tag, ".serr"}, n_serr - b_serr, e_serr);
    chk({tag, ".lerr"}, n_lerr - b_lerr, e_lerr);
  endtask

  // Drive a line state at the current negedge and hold it n clocks.
  task automatic drv(input line_state_t s, input int n);
    case (s)
      LINE_J:   {bus.d_plus_sync, bus.d_minus_sync} = 2'b10;
      LINE_K:   {bus.d_plus_sync, bus.d_minus_sync} = 2'b01;
      LINE_SE0: {bus.d_plus_sync, bus.d_minus_sync} = 2'b00;
      default:  {bus.d_plus_sync, bus.d_minus_sync} = 2'b11;
    endcase
    repeat (n) @(negedge clk);
  endtask

  // Arm and send KJKJKJKK; l3/l4 stretch bits 3 and 4 for jitter.
  task automatic sync(input int l3, input int l4);
    bus.enable = 1'b1;
    t_sync = cyc;
    drv(LINE_K, 8); drv(LINE_J, 8); drv(LINE_K, 8); drv(LINE_J, l3);
    drv(LINE_K, l4); drv(LINE_J, 8); drv(LINE_K, 8); drv(LINE_K, 8);
    ex(1'b0, 7); ex(1'b1, 1);
  endtask

  // Disarm together with the return to J so idle J is never sampled.
  task automatic idle();
    bus.enable = 1'b0;
    drv(LINE_J, 8);
  endtask

  int t_se0;

  initial begin
    bus.enable = 1'b0;
    {bus.d_plus_sync, bus.d_minus_sync} = 2'b10;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.bit_valid", int'(bus.bit_valid), 0);
    chk("rst.bit_out",   int'(bus.bit_out),   0);
    chk("rst.eop",       int'(bus.eop),       0);
    chk("rst.stuff_err", int'(bus.stuff_err), 0);
    chk("rst.line_err",  int'(bus.line_err),  0);
    n_rst = 1'b1;

    mark();
    repeat (64) @(negedge clk);
    verify("idle", 0, 0, 0);

    // Sync byte; edge cycle is t_sync, first strobe output 4 clocks later.
    mark();
    sync(8, 8);
    if (got_q.size() > b_bits) chk("sync.lat", bv_cyc_q[b_bits] - t_sync, 4);
    else chk("sync.lat", -1, 4);
    idle();
    verify("sync", 0, 0, 0);

    // Six 1s, stuffed K (no strobe), a 0, then EOP.
    mark();
    sync(8, 8);
    drv(LINE_J, 8);  ex(1'b0, 1);
    drv(LINE_J, 48); ex(1'b1, 6);
    drv(LINE_K, 8);
    drv(LINE_J, 8);  ex(1'b0, 1);
    t_se0 = cyc;
    drv(LINE_SE0, 16);
    idle();
    verify("stuff", 1, 0, 0);
    if (n_eop > b_eop) chk("stuff.eop_lat", eop_cyc_q[eop_cyc_q.size() - 1] - t_se0, 12);
    else chk("stuff.eop_lat", -1, 12);

    // Seventh 1 in the stuff slot; then a 3-bit SE0 still gives one eop.
    mark();
    sync(8, 8);
    drv(LINE_J, 8);  ex(1'b0, 1);
    drv(LINE_J, 56); ex(1'b1, 6);
    drv(LINE_SE0, 24);
    idle();
    verify("serr", 1, 1, 0);

    // Single SE0 bit then J: not an EOP, J decodes as 0 after K.
    mark();
    sync(8, 8);
    drv(LINE_SE0, 8);
    drv(LINE_J, 8); ex(1'b0, 1);
    idle();
    verify("se0x1", 0, 0, 0);

    // Jitter: 6-clock bit followed by a 10-clock bit.
    mark();
    sync(6, 10);
    idle();
    verify("jit", 0, 0, 0);

    // SE1 for one bit, then J decodes against the last K.
    mark();
    sync(8, 8);
    drv(LINE_SE1, 8);
    drv(LINE_J, 8); ex(1'b0, 1);
    idle();
    verify("se1", 0, 0, 1);

    // Drop enable after a K sample; lines keep toggling with no pulses.
    mark();
    bus.enable = 1'b1;
    drv(LINE_K, 8); drv(LINE_J, 8); drv(LINE_K, 8); ex(1'b0, 3);
    bus.enable = 1'b0;
    drv(LINE_J, 8); drv(LINE_K, 8); drv(LINE_J, 8);
    verify("abort", 0, 0, 0);
    mark();
    sync(8, 8);
    idle();
    verify("reen", 0, 0, 0);

    // Reset pulse at phase 2 of the first K: its sample never happens.
    mark();
    bus.enable = 1'b1;
    drv(LINE_K, 2);
    n_rst = 1'b0;
    bus.enable = 1'b0;
    drv(LINE_J, 1);
    chk("midrst.bit_valid", int'(bus.bit_valid), 0);
    n_rst = 1'b1;
    repeat (16) @(negedge clk);
    verify("midrst", 0, 0, 0);
    mark();
    sync(8, 8);
    idle();
    verify("postrst", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rx_bit_recovery.md
Name: rx_bit_recovery

Overview:
- Downstream consumer of the USB D+/D− metastability synchronizers.
- Recovers bit timing from the synchronized line using an 8x-oversampled phase counter that resyncs on every data edge.
- Decodes NRZI, removes stuffed bits, and flags EOP, stuff errors and illegal SE1.
- Feeds the receive shift register and the RX control unit with one-cycle `bit_valid` strobes.

Parameters:
- CLKS_PER_BIT, 8 — clk cycles per USB bit period.
- SAMPLE_POINT, 3 — phase count at which the line is sampled; range 1..CLKS_PER_BIT-1.
- MAX_ONES, 6 — consecutive decoded 1s after which the next bit is a stuff bit.

Ports:
- clk, input, 1 — system clock, CLKS_PER_BIT x bit rate.
- n_rst, input, 1 — asynchronous, active-low reset.
- enable, input, 1 — receiver armed; when low, the block is held in its idle state.
- d_plus_sync, input, 1 — synchronized D+, reset-idles high.
- d_minus_sync, input, 1 — synchronized D−, reset-idles low.
- bit_valid, output, 1 — one-cycle strobe: `bit_out` holds a decoded, unstuffed data bit.
- bit_out, output, 1 — decoded data bit.
- eop, output, 1 — one-cycle pulse on a confirmed end-of-packet.
- stuff_err, output, 1 — one-cycle pulse: a 1 was found where a stuff bit was expected.
- line_err, output, 1 — one-cycle pulse: SE1 (both lines high) was sampled.

Behaviour:
- Clock and reset: clk, with asynchronous active-low n_rst.
- Reset state:
  - All outputs 0.
  - phase = 0, prev_dp = 1, prev_line = 1 (J), ones_cnt = 0, se0_cnt = 0.
- Reset mid-packet returns immediately to the reset state; the partial packet is discarded with no pulses.
- Line classification: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1), as (d_plus_sync, d_minus_sync).
- Edge detect: `edge` = (d_plus_sync != prev_dp); prev_dp updates every cycle.
- Phase counter (width $clog2(CLKS_PER_BIT)):
  - enable low → phase <= 0.
  - Otherwise, edge → phase <= 1, so the edge cycle counts as phase 0.
  - Otherwise, phase <= (phase == CLKS_PER_BIT-1) ? 0 : phase+1.
- Sample strobe `samp` = enable && !edge && phase == SAMPLE_POINT, combinational.
  - An edge coinciding with SAMPLE_POINT suppresses the sample; the counter resyncs instead.
- Latency: all outputs are registered on the `samp` edge and are high for exactly one cycle, the cycle with phase == SAMPLE_POINT+1.
- Nominal timing: the first strobe occurs SAMPLE_POINT cycles after an edge; outputs follow one cycle later.
- On `samp`, by sampled line state:
  - SE0:
    - se0_cnt++, saturating at 2.
    - When se0_cnt reaches 2 (second consecutive SE0 sample): eop=1, ones_cnt<=0, prev_line<=1.
    - No bit_valid.
  - SE1:
    - line_err=1, se0_cnt<=0.
    - No bit_valid; prev_line and ones_cnt unchanged.
  - J or K:
    - se0_cnt<=0; dec = (d_plus_sync == prev_line); prev_line<=d_plus_sync.
    - If ones_cnt == MAX_ONES:
      - Stuff slot; no bit_valid; ones_cnt<=0.
      - If dec == 1, stuff_err=1.
    - Else:
      - bit_valid=1, bit_out=dec.
      - ones_cnt <= dec ? ones_cnt+1 : 0.
- bit_out holds its last value between strobes and is meaningful only with bit_valid.
- enable low:
  - ones_cnt<=0, se0_cnt<=0, prev_line<=1.
  - No pulses.
- Rising enable starts sampling with a fresh phase.
- A single SE0 sample followed by J/K is not an EOP: se0_cnt is cleared.
- More than 2 SE0 samples produce only one eop pulse, because se0_cnt saturates and the pulse fires only on the 1→2 transition.

Decomposition:
- Package usb_rx_pkg:
  - typedef enum line_state_t {LINE_J, LINE_K, LINE_SE0, LINE_SE1}.
  - Localparams for default CLKS_PER_BIT, SAMPLE_POINT and MAX_ONES.
- Sub-module bit_phase_timer: the phase counter plus edge detect; outputs `samp`.
- The top level holds the NRZI decode, unstuff and EOP logic.

Test Plan:
- Reset: hold n_rst low with lines at J, release, keep enable=0 for 64 clk → all outputs stay 0, no strobes.
- Sync byte: enable=1, then drive K J K J K J K K at 8 clk/bit → bit_valid 8 times; bit_out = 0,0,0,0,0,0,0,1; first bit_valid 4 clk after the first K edge.
- Bit stuffing:
  - Drive 7 bit periods unchanged (ones) after a K, then a transition → six bit_valid with bit_out=1; the stuffed bit gives no strobe; the following bit is decoded normally.
  - Variant with no transition on the 7th bit → stuff_err pulse, no bit_valid.
- EOP:
  - SE0 for 2 bit times, then J → exactly one eop pulse at the second SE0 sample, no bit_valid during SE0.
  - A 1-bit SE0 followed by J → no eop.
- Jitter: shorten one bit to 6 clk and lengthen the next to 10 clk → phase resyncs on each edge; every bit is sampled exactly once; decoded bits are correct.
- Abort and errors:
  - Drop enable mid-packet, or pulse n_rst at phase 2 → no further pulses; after re-enable with the sync pattern, decoding is correct.
  - Drive SE1 for one bit → one line_err pulse.
